// File: rtl/pipe_credit_fifo.sv
// Credit-gated receive FIFO behind a fixed-latency delay pipeline.
// Issue is permitted only while an unreserved FIFO slot exists, so pipeline output always has a home.
module pipe_credit_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     pipe_valid,
  input  logic [DW-1:0]            pipe_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DW-1:0]            m_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           overflow_q, overflow_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic [DW-1:0]  mem_d [DEPTH];

  logic empty_c, full_c, issue_fire_c, pop_fire_c, wr_fire_c;

  // Pointer status and handshake qualification
  always_comb begin
    empty_c      = (wr_ptr_q == rd_ptr_q);
    full_c       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    issue_fire_c = issue_valid && (credits_q != '0);
    pop_fire_c   = !empty_c && m_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    wr_fire_c    = pipe_valid && (!full_c || pop_fire_c);
  end

  // Next-state for storage, pointers, credits and sticky overflow
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    credits_d  = credits_q;
    overflow_d = overflow_q;

    if (wr_fire_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = pipe_data;
      wr_ptr_d                = wr_ptr_q + CW'(1);
    end
    if (pop_fire_c) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
    if (pipe_valid && full_c && !pop_fire_c) begin
      overflow_d = 1'b1;
    end

    if (issue_fire_c && !pop_fire_c) begin
      credits_d = credits_q - CW'(1);
    end else if (pop_fire_c && !issue_fire_c && (credits_q != CW'(DEPTH))) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      credits_q  <= CW'(DEPTH);
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  // Outputs are decoded purely from registered state; head reads as zero when empty
  always_comb begin
    issue_ready = (credits_q != '0);
    m_valid     = !empty_c;
    m_data      = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    count       = wr_ptr_q - rd_ptr_q;
    credits     = credits_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Scoreboard bench for pipe_credit_fifo: DEPTH=4, DW=8, delay pipeline of latency 4 modelled here.
module tb_pipe_credit_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          pipe_valid = 1'b0;
  logic [DW-1:0] pipe_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic [CW-1:0] credits;
  logic          overflow;

  pipe_credit_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pipe_valid  (pipe_valid),
    .pipe_data   (pipe_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .credits     (credits),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned n_pops = 0;

  // Bench-side model state
  logic [DW-1:0] exp_q[$];
  int unsigned   m_count;
  int unsigned   m_cred;
  logic          m_ovf;
  logic [DW-1:0] next_val;
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_count = 0;
    m_cred  = DEPTH;
    m_ovf   = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  // Called at a negedge; asserts reset, checks the asynchronous effect, holds across one edge
  task automatic apply_reset();
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    m_ready     = 1'b0;
    pipe_valid  = 1'b1;
    pipe_data   = 8'hEE;
    #1;
    chk("rst_m_valid",     32'(m_valid),     32'd0);
    chk("rst_count",       32'(count),       32'd0);
    chk("rst_credits",     32'(credits),     32'(DEPTH));
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_overflow",    32'(overflow),    32'd0);
    chk("rst_m_data",      32'(m_data),      32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    pipe_valid = 1'b0;
    clear_model();
  endtask

  // One clock: drive inputs at negedge, check against model, advance model over the posedge
  task automatic do_cycle(input logic iv, input logic mr, input logic inj_v, input logic [DW-1:0] inj_d);
    logic i_fire, p_fire, w_fire;
    issue_valid = iv;
    m_ready     = mr;
    pipe_valid  = pv[LAT-1] | inj_v;
    pipe_data   = inj_v ? inj_d : pd[LAT-1];
    #1;
    chk("issue_ready", 32'(issue_ready), 32'(m_cred != 0));
    chk("m_valid",     32'(m_valid),     32'(m_count != 0));
    chk("count",       32'(count),       32'(m_count));
    chk("credits",     32'(credits),     32'(m_cred));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    if (m_count == 0) chk("m_data_empty", 32'(m_data), 32'd0);
    else if (exp_q.size() != 0) chk("m_data_head", 32'(m_data), 32'(exp_q[0]));

    i_fire = iv && (m_cred != 0);
    p_fire = mr && (m_count != 0);
    w_fire = pipe_valid && ((m_count < DEPTH) || p_fire);

    if (p_fire) begin
      n_pops++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (i_fire) exp_q.push_back(next_val);
    if (inj_v && w_fire) exp_q.push_back(inj_d);
    if (pipe_valid && !w_fire) m_ovf = 1'b1;
    m_count = m_count + (w_fire ? 1 : 0) - (p_fire ? 1 : 0);
    if (i_fire && !p_fire) m_cred--;
    else if (p_fire && !i_fire && m_cred < DEPTH) m_cred++;

    @(posedge clk);
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = i_fire;
    pd[0] = next_val;
    if (i_fire) next_val = next_val + 8'd1;
    @(negedge clk);
  endtask

  initial begin
    next_val = 8'h11;
    clear_model();
    @(negedge clk);
    apply_reset();

    // Fill: issue held, consumer stalled
    for (int i = 0; i < 12; i++) do_cycle(1'b1, 1'b0, 1'b0, '0);
    chk("fill_count",   32'(count),   32'd4);
    chk("fill_credits", 32'(credits), 32'd0);
    // Drain in order
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);
    chk("drain_credits", 32'(credits), 32'd4);
    chk("drain_m_valid", 32'(m_valid), 32'd0);

    // Streaming at full rate
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++)  do_cycle(1'b0, 1'b1, 1'b0, '0);

    // Overflow: write into full FIFO with no pop
    apply_reset();
    next_val = 8'h11;
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b0, 1'b1, 8'hAA);
    do_cycle(1'b0, 1'b0, 1'b0, '0);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd4);
    chk("ovf_head",  32'(m_data),   32'h11);

    // Full FIFO accepts a write when the head pops in the same cycle
    apply_reset();
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("fullpop_count", 32'(count),    32'd4);
    chk("fullpop_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);

    // Wrap: ten items with random consumer back-pressure
    apply_reset();
    n_pops = 0;
    begin
      int unsigned issued = 0;
      for (int i = 0; i < 40; i++) begin
        logic iv;
        iv = (issued < 10);
        if (iv && m_cred != 0) issued++;
        do_cycle(iv, 1'($urandom_range(0, 1)), 1'b0, '0);
      end
    end
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pops", 32'(n_pops), 32'd10);

    // Reset mid-operation with count 3, credits 0, one item in flight
    apply_reset();
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 1'b0, '0);
    chk("pre_rst_count",   32'(count),   32'd3);
    chk("pre_rst_credits", 32'(credits), 32'd0);
    apply_reset();
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0, 1'b0, '0);
    // First operations honoured right after reset release
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
